// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the UART receive DI buffer.
// Word layout: [23:0] bytes (first byte in [7:0]), [25:24] byte count,
// [29:26] zero, [30] framing error seen, [31] earlier word dropped.
package uart_rx_buf_pkg;

    localparam int CNT_LSB  = 24;
    localparam int FERR_BIT = 30;
    localparam int OVF_BIT  = 31;

    localparam logic [31:0] REG_DATA  = 32'd0;
    localparam logic [31:0] REG_LEVEL = 32'd1;

    localparam logic [15:0] ST_OK        = 16'h0000;
    localparam logic [15:0] ST_UNDERFLOW = 16'h0001;

    function automatic logic [31:0] pack_word(input logic ovf, input logic ferr,
                                              input logic [1:0] cnt, input logic [23:0] bytes);
        logic [31:0] w;
        w                     = '0;
        w[23:0]               = bytes;
        w[CNT_LSB +: 2]       = cnt;
        w[FERR_BIT]           = ferr;
        w[OVF_BIT]            = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst_n (async active-low), push/wdata write side, pop read side,
// rdata always shows the head word, full/empty flags and level (word count).
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the caller is expected to account for it.
module sync_word_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [W-1:0]          wdata,
    input  logic                  pop,
    output logic [W-1:0]          rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]            mem_q [DEPTH];
    logic [W-1:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
    logic                    wr_en, rd_en;

    assign full  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign level = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_di_buffer.sv
// Receive-side buffer: packs UART bytes into tagged 32-bit words, queues them
// and serves DI reads (address 0 = data, 1 = level) for this terminal.
// Ports: ifclk/resetb (async active-low); rx_byte/rx_valid/rx_ferr from the
// byte receiver; term_addr = own terminal; di_* = DI read interface;
// fifo_level = words queued.
module uart_rx_di_buffer
    import uart_rx_buf_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int TIMEOUT_CYC = 4800,
    parameter int TW          = 16
) (
    input  logic                  ifclk,
    input  logic                  resetb,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  rx_ferr,
    input  logic [15:0]           term_addr,
    input  logic [15:0]           di_term_addr,
    input  logic [31:0]           di_reg_addr,
    input  logic                  di_read_mode,
    input  logic                  di_read_req,
    input  logic                  di_read,
    output logic                  di_read_rdy,
    output logic [31:0]           di_reg_datao,
    output logic [15:0]           di_transfer_status,
    output logic                  di_en,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    logic [23:0]   pkt_data_q, pkt_data_d;
    logic [1:0]    pkt_cnt_q,  pkt_cnt_d;
    logic          pkt_ferr_q, pkt_ferr_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic          ovf_q,      ovf_d;
    logic          bubble_q,   bubble_d;
    logic [15:0]   status_q,   status_d;

    logic          data_sel, lvl_sel, flush_req, tmo_hit, pkt_push;
    logic          fifo_pop, fifo_full, fifo_empty, drop, underflow;
    logic [31:0]   push_word, head_word;

    sync_word_fifo #(.W(32), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (ifclk),
        .rst_n (resetb),
        .push  (pkt_push),
        .wdata (push_word),
        .pop   (fifo_pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        di_en     = (di_term_addr == term_addr);
        data_sel  = (di_reg_addr == REG_DATA);
        lvl_sel   = (di_reg_addr == REG_LEVEL);
        flush_req = di_read_req & di_en & data_sel & (pkt_cnt_q != 2'd0);
        tmo_hit   = (pkt_cnt_q != 2'd0) & (tmo_q == TW'(TIMEOUT_CYC - 1));
        // Full word, host flush and timeout all push the same packer word,
        // so whichever fires, exactly one push happens.
        pkt_push  = (pkt_cnt_q == 2'd3) | flush_req | tmo_hit;
        push_word = pack_word(ovf_q, pkt_ferr_q, pkt_cnt_q, pkt_data_q);
        fifo_pop  = di_read & di_en & data_sel & ~fifo_empty;
        underflow = di_read & di_en & data_sel & fifo_empty;
        drop      = pkt_push & fifo_full & ~fifo_pop;

        ovf_d = ovf_q;
        if (drop)          ovf_d = 1'b1;
        else if (pkt_push) ovf_d = 1'b0;

        // Packer: a flush empties it; a byte in the same cycle starts afresh.
        pkt_data_d = pkt_data_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_ferr_d = pkt_ferr_q;
        if (pkt_push) begin
            pkt_data_d = '0;
            pkt_cnt_d  = 2'd0;
            pkt_ferr_d = 1'b0;
        end
        if (rx_valid) begin
            pkt_data_d[{pkt_cnt_d, 3'b000} +: 8] = rx_byte;
            pkt_cnt_d  = pkt_cnt_d + 2'd1;
            pkt_ferr_d = pkt_ferr_d | rx_ferr;
        end

        tmo_d = tmo_q;
        if (rx_valid || pkt_push)   tmo_d = '0;
        else if (pkt_cnt_q != 2'd0) tmo_d = tmo_q + 1'b1;

        // After a pop the next head is held off for one cycle.
        bubble_d = fifo_pop;

        status_d = status_q;
        if (di_read_req) status_d = ST_OK;
        if (underflow)   status_d = ST_UNDERFLOW;
    end

    always_comb begin
        di_read_rdy  = 1'b0;
        di_reg_datao = '0;
        if (di_en) begin
            if (data_sel) begin
                di_read_rdy  = di_read_mode & ~fifo_empty & ~bubble_q;
                di_reg_datao = fifo_empty ? 32'd0 : head_word;
            end else if (lvl_sel) begin
                di_read_rdy  = di_read_mode;
                di_reg_datao = 32'(fifo_level);
            end
        end
    end

    assign di_transfer_status = status_q;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            pkt_data_q <= '0;
            pkt_cnt_q  <= '0;
            pkt_ferr_q <= 1'b0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            bubble_q   <= 1'b0;
            status_q   <= ST_OK;
        end else begin
            pkt_data_q <= pkt_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_ferr_q <= pkt_ferr_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            bubble_q   <= bubble_d;
            status_q   <= status_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_di_buffer.sv
// Directed bench for uart_rx_di_buffer with hand-computed expected values.
module tb_uart_rx_di_buffer;

    logic        ifclk = 1'b0;
    logic        resetb;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr;
    logic [15:0] term_addr, di_term_addr;
    logic [31:0] di_reg_addr;
    logic        di_read_mode, di_read_req, di_read;
    logic        di_read_rdy;
    logic [31:0] di_reg_datao;
    logic [15:0] di_transfer_status;
    logic        di_en;
    logic [6:0]  fifo_level;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_di_buffer dut (
        .ifclk              (ifclk),
        .resetb             (resetb),
        .rx_byte            (rx_byte),
        .rx_valid           (rx_valid),
        .rx_ferr            (rx_ferr),
        .term_addr          (term_addr),
        .di_term_addr       (di_term_addr),
        .di_reg_addr        (di_reg_addr),
        .di_read_mode       (di_read_mode),
        .di_read_req        (di_read_req),
        .di_read            (di_read),
        .di_read_rdy        (di_read_rdy),
        .di_reg_datao       (di_reg_datao),
        .di_transfer_status (di_transfer_status),
        .di_en              (di_en),
        .fifo_level         (fifo_level)
    );

    always #5 ifclk = ~ifclk;

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_byte  = b;
        rx_ferr  = fe;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic pop_word();
        di_read = 1'b1;
        tick();
        di_read = 1'b0;
        tick();
    endtask

    initial begin
        resetb = 1'b0; rx_byte = '0; rx_valid = 1'b0; rx_ferr = 1'b0;
        term_addr = 16'h0005; di_term_addr = 16'h0000; di_reg_addr = 32'd0;
        di_read_mode = 1'b0; di_read_req = 1'b0; di_read = 1'b0;
        #2;
        chk("rst_level",  32'(fifo_level), 32'd0);
        chk("rst_rdy",    32'(di_read_rdy), 32'd0);
        chk("rst_data",   di_reg_datao, 32'd0);
        chk("rst_status", 32'(di_transfer_status), 32'd0);
        chk("rst_en",     32'(di_en), 32'd0);
        tick(); tick();
        resetb = 1'b1;
        tick();
        di_term_addr = 16'h0005;
        di_read_mode = 1'b1;
        #1;
        chk("en_match", 32'(di_en), 32'd1);

        // Full 3-byte word and its latency.
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        chk("w3_rdy_n1",   32'(di_read_rdy), 32'd0);
        chk("w3_level_n1", 32'(fifo_level), 32'd0);
        tick();
        chk("w3_rdy_n2",   32'(di_read_rdy), 32'd1);
        chk("w3_level",    32'(fifo_level), 32'd1);
        chk("w3_data",     di_reg_datao, 32'h0343_4241);
        di_term_addr = 16'h0006;
        #1;
        chk("noen_data",   di_reg_datao, 32'd0);
        chk("noen_rdy",    32'(di_read_rdy), 32'd0);
        di_term_addr = 16'h0005;
        di_read = 1'b1;
        tick();
        di_read = 1'b0;
        chk("w3_pop_level", 32'(fifo_level), 32'd0);
        chk("w3_pop_rdy",   32'(di_read_rdy), 32'd0);
        chk("w3_pop_data",  di_reg_datao, 32'd0);

        // Idle timeout flush of a single byte.
        send_byte(8'h55, 1'b0);
        repeat (4798) tick();
        chk("tmo_4798", 32'(fifo_level), 32'd0);
        tick();
        chk("tmo_4799", 32'(fifo_level), 32'd0);
        tick();
        chk("tmo_4800_level", 32'(fifo_level), 32'd1);
        chk("tmo_4800_data",  di_reg_datao, 32'h0100_0055);
        pop_word();

        // Host request flush, timeout must not fire afterwards.
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        repeat (10) tick();
        chk("req_pre_level", 32'(fifo_level), 32'd0);
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        chk("req_level", 32'(fifo_level), 32'd1);
        chk("req_data",  di_reg_datao, 32'h0200_2010);
        repeat (4900) tick();
        chk("req_no_second_push", 32'(fifo_level), 32'd1);
        pop_word();

        // Framing error tag.
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        tick();
        chk("ferr_data", di_reg_datao, 32'h4302_017E);
        pop_word();
        chk("ferr_empty", 32'(fifo_level), 32'd0);

        // Overflow: 65 words into a 64-word FIFO.
        for (int j = 0; j < 195; j++) send_byte(8'(j), 1'b0);
        tick();
        chk("ovf_level", 32'(fifo_level), 32'd64);
        chk("ovf_head",  di_reg_datao, 32'h0302_0100);
        di_reg_addr = 32'd1;
        #1;
        chk("lvl_reg_data", di_reg_datao, 32'd64);
        chk("lvl_reg_rdy",  32'(di_read_rdy), 32'd1);
        di_read = 1'b1;
        tick();
        di_read = 1'b0;
        chk("lvl_reg_noside", 32'(fifo_level), 32'd64);
        di_reg_addr = 32'd0;
        pop_word();
        chk("ovf_pop_level", 32'(fifo_level), 32'd63);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        tick();
        chk("ovf_refill_level", 32'(fifo_level), 32'd64);
        chk("ovf_head1", di_reg_datao, 32'h0305_0403);
        repeat (62) pop_word();
        chk("ovf_head63", di_reg_datao, 32'h03BF_BEBD);
        pop_word();
        chk("ovf_tag_word", di_reg_datao, 32'h83CC_BBAA);
        chk("ovf_tag_level", 32'(fifo_level), 32'd1);
        pop_word();

        // Underflow and status clear.
        di_read = 1'b1;
        tick();
        di_read = 1'b0;
        chk("uf_data",   di_reg_datao, 32'd0);
        chk("uf_status", 32'(di_transfer_status), 32'h0001);
        chk("uf_level",  32'(fifo_level), 32'd0);
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        chk("uf_clear", 32'(di_transfer_status), 32'h0000);

        // Reset mid-packing.
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        tick();
        chk("prerst_level", 32'(fifo_level), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_rdy",   32'(di_read_rdy), 32'd0);
        tick();
        resetb = 1'b1;
        tick();
        send_byte(8'h99, 1'b0);
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        chk("postrst_word", di_reg_datao, 32'h0100_0099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
